// File: rtl/obi_ext_master_buffer.sv
// obi_ext_master_buffer: request FIFO and outstanding-transaction limiter
// between the external-core crossbar and the mochila_top master port.
// Optional watchdog with synthetic error completion: OBI_EXT_BUF_TIMEOUT_EN.
module obi_ext_master_buffer #(
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          TIMEOUT_CYCLES  = 1024,
    parameter logic [31:0] TIMEOUT_RDATA   = 32'hBADC_AB1E
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        master_req_i,
    input  logic        master_we_i,
    input  logic [3:0]  master_be_i,
    input  logic [31:0] master_addr_i,
    input  logic [31:0] master_wdata_i,
    output logic        master_gnt_o,
    output logic        master_rvalid_o,
    output logic [31:0] master_rdata_o,
    output logic        slave_req_o,
    output logic        slave_we_o,
    output logic [3:0]  slave_be_o,
    output logic [31:0] slave_addr_o,
    output logic [31:0] slave_wdata_o,
    input  logic        slave_gnt_i,
    input  logic        slave_rvalid_i,
    input  logic [31:0] slave_rdata_i,
    output logic [3:0]  outstanding_o,
    output logic        fifo_full_o,
    output logic        timeout_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + 4 + 32 + 32;
    localparam logic [3:0] MAX_OS = 4'(MAX_OUTSTANDING);

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [3:0]    fwd_cnt;
    logic [3:0]    drop_cnt;
    logic [3:0]    in_flight;
    logic          fwd_rsp;
    logic          retire;
    logic          timeout_fire;

    // Extra pointer bit separates full (MSBs differ) from empty (equal).
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign head  = mem[rptr[AW-1:0]];

    assign in_flight     = fwd_cnt + drop_cnt;
    assign outstanding_o = in_flight;
    assign fifo_full_o   = full;

    assign master_gnt_o = !full && !rst_i;
    assign push         = master_req_i && master_gnt_o;

    assign slave_req_o = !empty && (in_flight < MAX_OS) && !rst_i;
    assign pop         = slave_req_o && slave_gnt_i;
    assign {slave_we_o, slave_be_o, slave_addr_o, slave_wdata_o} =
        slave_req_o ? head : '0;

    // Responses only pass through once every timed-out answer is swallowed.
    assign fwd_rsp = slave_rvalid_i && (drop_cnt == 4'd0) && !rst_i;
    assign retire  = fwd_rsp || timeout_fire;

    assign master_rvalid_o = retire;
    assign master_rdata_o  = timeout_fire ? TIMEOUT_RDATA :
                             fwd_rsp      ? slave_rdata_i : 32'd0;
    assign timeout_o       = timeout_fire;

    // FIFO storage write; contents need no reset, pointers gate validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= {master_we_i, master_be_i,
                                  master_addr_i, master_wdata_i};
        end
    end

    // FIFO pointers, wrapping modulo depth with the extra lap bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Forwarded in-flight count: +1 per issue, -1 per completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fwd_cnt <= 4'd0;
        end else begin
            fwd_cnt <= fwd_cnt + {3'd0, pop} - {3'd0, retire};
        end
    end

`ifdef OBI_EXT_BUF_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    logic [WDW-1:0] wd_cnt;
    logic           drop_rsp;

    assign drop_rsp     = slave_rvalid_i && (drop_cnt != 4'd0);
    assign timeout_fire = (fwd_cnt != 4'd0) && (wd_cnt == WD_LAST) &&
                          !slave_rvalid_i && !rst_i;

    // Watchdog: counts idle cycles of the oldest forwarded transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt <= '0;
        end else if (fwd_cnt == 4'd0 || fwd_rsp || timeout_fire) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_LAST) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Late answers owed by the slave for transactions already completed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt <= 4'd0;
        end else begin
            drop_cnt <= drop_cnt + {3'd0, timeout_fire} - {3'd0, drop_rsp};
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign drop_cnt     = 4'd0;
`endif

endmodule
